// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional SEQ_DIV_ZERO_SHORTCUT_EN: a zero divisor finishes in one cycle and flags div_by_zero.
module sequential_divider #(
    parameter int width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on an edge where state is IDLE or DONE; busy is
    // high from that edge until the edge that raises done; done lasts one cycle and
    // the result registers are valid from then until the next completion or reset.

    localparam int CW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   work_q, work_d;
    logic [width-1:0]   dvs_q, dvs_d;
    logic [width:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [width-1:0]   quo_q, quo_d;
    logic [width-1:0]   rmd_q, rmd_d;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
    logic               dbz_q, dbz_d;
`endif

    logic [width+1:0]   trial;
    logic               q_bit;
    logic [width:0]     step_rem;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
        dbz_d   = dbz_q;
`endif

        // The dividend register doubles as the quotient: its MSB is consumed each
        // step while the new quotient bit enters at the LSB.
        trial    = {rem_q, work_q[width-1]};
        q_bit    = (trial >= {2'b00, dvs_q});
        step_rem = q_bit ? (trial[width:0] - {1'b0, dvs_q}) : trial[width:0];

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    work_d  = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
                if (dvs_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = '1;
                    rmd_d   = work_q;
                    dbz_d   = 1'b1;
                end else begin
`else
                begin
`endif
                    work_d = {work_q[width-2:0], q_bit};
                    rem_d  = step_rem;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(width - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quo_d   = {work_q[width-2:0], q_bit};
                        rmd_d   = step_rem[width-1:0];
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
                        dbz_d   = 1'b0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign dbg_state = state_q;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
